comm_uart_sender: RTL and testbench

- Serializes game-state messages (ball handoff, miss/score, new game, new-game ack) into byte frames and transmits them 8N1 on UART_TXD to the peer board.
- Sits directly downstream of the game state machine and replaces the CommunicationSender stub.
- Uses the same send_new_message / message_sent producer handshake and the same *_tx message inputs.

---
 rtl/comm_uart_sender.sv | 148 ++++++++++++++
 tb/tb_comm_uart_sender.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_uart_sender.sv
// Game-message framer and 8N1 UART transmitter toward the peer board.
// A request latches the message into a 2-4 byte frame (header, payload, XOR checksum) sent LSB first.
module comm_uart_sender #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       send_new_message,
  output logic       busy,
  output logic       message_sent,
  input  logic       ball_message_tx,
  input  logic [8:0] ball_y_tx,
  input  logic [3:0] velocity_x_tx,
  input  logic [3:0] velocity_y_tx,
  input  logic       miss_message_tx,
  input  logic [4:0] my_score_tx,
  input  logic [4:0] your_score_tx,
  input  logic       you_should_serve_tx,
  input  logic       new_game_message_tx,
  input  logic       you_serve_first_tx,
  input  logic       new_game_ack_message_tx,
  input  logic       UART_CTS_N,
  output logic       UART_TXD
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [1:0]      last_q, last_d;
  logic [3:0][7:0] frame_q, frame_d;
  logic [3:0][7:0] frame_new;
  logic [1:0]      last_new;
  logic            txd_q, txd_d;
  logic            cts_s1_q, cts_s2_q;
  logic            cts_ok, accept, bit_done, counting;

  assign cts_ok       = !cts_s2_q;
  assign busy         = (state_q == LOAD) || (state_q == START) ||
                        (state_q == DATA) || (state_q == STOP);
  assign message_sent = (state_q == DONE);
  assign UART_TXD     = txd_q;
  assign accept       = send_new_message &&
                        (new_game_ack_message_tx || new_game_message_tx ||
                         miss_message_tx || ball_message_tx) &&
                        ((state_q == IDLE) || (state_q == DONE));

  // Frame image for the request on the inputs; highest-priority flag wins.
  always_comb begin
    frame_new = '0;
    last_new  = 2'd0;
    if (new_game_ack_message_tx) begin
      frame_new[0] = 8'hC0;
      frame_new[1] = 8'hC0;
      last_new     = 2'd1;
    end else if (new_game_message_tx) begin
      frame_new[0] = {2'b10, 5'b0, you_serve_first_tx};
      frame_new[1] = frame_new[0];
      last_new     = 2'd1;
    end else if (miss_message_tx) begin
      frame_new[0] = {2'b01, you_should_serve_tx, my_score_tx};
      frame_new[1] = {3'b0, your_score_tx};
      frame_new[2] = frame_new[0] ^ frame_new[1];
      last_new     = 2'd2;
    end else begin
      frame_new[0] = {7'b0, ball_y_tx[8]};
      frame_new[1] = ball_y_tx[7:0];
      frame_new[2] = {velocity_x_tx, velocity_y_tx};
      frame_new[3] = frame_new[0] ^ frame_new[1] ^ frame_new[2];
      last_new     = 2'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    last_d   = last_q;
    frame_d  = frame_q;
    counting = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    bit_done = counting && (cnt_q == CNT_MAX);
    cnt_d    = (counting && !bit_done) ? cnt_q + 1'b1 : '0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = LOAD;
          frame_d = frame_new;
          last_d  = last_new;
          byte_d  = 2'd0;
        end
      end
      LOAD:  if (cts_ok) state_d = START;
      START: if (bit_done) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (bit_done) begin
        if (bit_q == 3'd7) state_d = STOP;
        else               bit_d   = bit_q + 3'd1;
      end
      STOP: if (bit_done) begin
        if (byte_q == last_q) state_d = DONE;
        else begin
          state_d = LOAD;
          byte_d  = byte_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level is registered from the next state so TXD never glitches.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = frame_q[byte_d][bit_d];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      last_q   <= '0;
      frame_q  <= '0;
      txd_q    <= 1'b1;
      cts_s1_q <= 1'b1;
      cts_s2_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
      frame_q  <= frame_d;
      txd_q    <= txd_d;
      cts_s1_q <= UART_CTS_N;
      cts_s2_q <= cts_s1_q;
    end
  end

endmodule

// File: tb/tb_comm_uart_sender.sv
// Randomized bench for comm_uart_sender: a serial receiver decodes TXD and
// compares against frames built from the message rules.
module tb_comm_uart_sender;
  localparam int CPB = 4;

  logic clock = 1'b0, reset_L = 1'b0, send_new_message = 1'b0;
  logic ball_message_tx = 0, miss_message_tx = 0, new_game_message_tx = 0, new_game_ack_message_tx = 0;
  logic [8:0] ball_y_tx = '0;
  logic [3:0] velocity_x_tx = '0, velocity_y_tx = '0;
  logic [4:0] my_score_tx = '0, your_score_tx = '0;
  logic you_should_serve_tx = 0, you_serve_first_tx = 0, UART_CTS_N = 1'b0;
  logic busy, message_sent, UART_TXD;

  comm_uart_sender #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset_L(reset_L), .send_new_message(send_new_message),
    .busy(busy), .message_sent(message_sent),
    .ball_message_tx(ball_message_tx), .ball_y_tx(ball_y_tx),
    .velocity_x_tx(velocity_x_tx), .velocity_y_tx(velocity_y_tx),
    .miss_message_tx(miss_message_tx), .my_score_tx(my_score_tx),
    .your_score_tx(your_score_tx), .you_should_serve_tx(you_should_serve_tx),
    .new_game_message_tx(new_game_message_tx), .you_serve_first_tx(you_serve_first_tx),
    .new_game_ack_message_tx(new_game_ack_message_tx),
    .UART_CTS_N(UART_CTS_N), .UART_TXD(UART_TXD));

  always #5 clock = ~clock;

  typedef struct {
    logic ball, miss, ng, ack;
    logic [8:0] y;
    logic [3:0] vx, vy;
    logic [4:0] my, your;
    logic serve, sf;
  } msg_t;

  int n_chk = 0, n_fail = 0, sent_cnt = 0, exp_sent = 0;
  logic [7:0] exp_q[$];

  always @(negedge clock) if (message_sent === 1'b1) sent_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected byte stream from the message rules (header, payload, XOR checksum).
  task automatic model(input msg_t m);
    int x;
    exp_q.delete();
    if (m.ack) exp_q.push_back(8'(192));
    else if (m.ng) exp_q.push_back(8'(128 + m.sf));
    else if (m.miss) begin
      exp_q.push_back(8'(64 + 32 * m.serve + m.my));
      exp_q.push_back(8'(m.your));
    end else if (m.ball) begin
      exp_q.push_back(8'(m.y / 256));
      exp_q.push_back(8'(m.y % 256));
      exp_q.push_back(8'(16 * m.vx + m.vy));
    end
    if (exp_q.size() > 0) begin
      x = 0;
      foreach (exp_q[i]) x = x ^ exp_q[i];
      exp_q.push_back(8'(x));
    end
  endtask

  function automatic msg_t rand_msg();
    msg_t m;
    {m.ack, m.ng, m.miss, m.ball} = 4'($urandom_range(0, 15));
    m.y = 9'($urandom); m.vx = 4'($urandom); m.vy = 4'($urandom);
    m.my = 5'($urandom); m.your = 5'($urandom);
    m.serve = 1'($urandom); m.sf = 1'($urandom);
    return m;
  endfunction

  // Called at a negedge; request is seen by the next posedge, then inputs are scrambled.
  task automatic start_req(input msg_t m);
    ball_message_tx = m.ball; miss_message_tx = m.miss;
    new_game_message_tx = m.ng; new_game_ack_message_tx = m.ack;
    ball_y_tx = m.y; velocity_x_tx = m.vx; velocity_y_tx = m.vy;
    my_score_tx = m.my; your_score_tx = m.your;
    you_should_serve_tx = m.serve; you_serve_first_tx = m.sf;
    send_new_message = 1'b1;
    @(negedge clock);
    send_new_message = 1'b0;
    {new_game_ack_message_tx, new_game_message_tx, miss_message_tx, ball_message_tx} = 4'b0;
    ball_y_tx = 9'($urandom); velocity_x_tx = 4'($urandom); my_score_tx = 5'($urandom);
  endtask

  task automatic rx_byte(output logic [7:0] b, input int bound, output int waits);
    waits = 0;
    b = 'x;
    while (UART_TXD !== 1'b0 && waits < bound) begin
      @(negedge clock);
      waits++;
    end
    if (UART_TXD !== 1'b0) begin
      chk("rx_start_timeout", 1, 0);
      return;
    end
    repeat (CPB / 2) @(negedge clock);
    chk("start_bit", UART_TXD, 0);
    chk("busy_in_frame", busy, 1);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clock);
      b[i] = UART_TXD;
      chk("busy_in_frame", busy, 1);
    end
    repeat (CPB) @(negedge clock);
    chk("stop_bit", UART_TXD, 1);
  endtask

  // Receives exp_q and returns at the negedge of the message_sent cycle.
  task automatic recv_frame(input int bound, output int first_wait);
    logic [7:0] b;
    int w, k;
    first_wait = 0;
    foreach (exp_q[i]) begin
      rx_byte(b, bound, w);
      if (i == 0) first_wait = w;
      chk("frame_byte", b, exp_q[i]);
    end
    k = 0;
    while (message_sent !== 1'b1 && k < 10) begin
      @(negedge clock);
      k++;
    end
    chk("msg_sent_seen", message_sent, 1);
    chk("busy_in_done", busy, 0);
    exp_sent++;
  endtask

  task automatic idle_check(input string tag, input int n);
    int lows = 0, busys = 0;
    repeat (n) begin
      @(negedge clock);
      if (UART_TXD !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    chk(tag, lows, 0);
    chk({tag, "_busy"}, busys, 0);
    chk({tag, "_sent"}, sent_cnt, exp_sent);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    msg_t m, m2;
    int w;
    #13;
    chk("rst_txd", UART_TXD, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sent", message_sent, 0);
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    repeat (3) @(negedge clock);

    // Ball: 01 A5 3E 9A
    m = '{ball:1, miss:0, ng:0, ack:0, y:9'h1A5, vx:4'd3, vy:4'hE, my:0, your:0, serve:0, sf:0};
    model(m); start_req(m); recv_frame(20, w);
    chk("first_start_latency", w, 1);
    idle_check("after_ball", 10);

    // Miss: 67 0B 6C
    m = '{ball:0, miss:1, ng:0, ack:0, y:0, vx:0, vy:0, my:5'd7, your:5'd11, serve:1, sf:0};
    model(m); start_req(m); recv_frame(20, w);
    idle_check("after_miss", 10);

    // Ack beats new game, then a new game request issued in the DONE cycle.
    m = '{ball:1, miss:1, ng:1, ack:1, y:0, vx:0, vy:0, my:0, your:0, serve:0, sf:1};
    model(m); start_req(m); recv_frame(20, w);
    m2 = '{ball:0, miss:0, ng:1, ack:0, y:0, vx:0, vy:0, my:0, your:0, serve:0, sf:1};
    model(m2); start_req(m2); recv_frame(20, w);
    chk("b2b_gap", w, 1);
    idle_check("after_b2b", 10);

    // No select flag: ignored.
    m = '{ball:0, miss:0, ng:0, ack:0, y:9'h1FF, vx:4'hF, vy:4'hF, my:5'd31, your:5'd31, serve:1, sf:1};
    start_req(m);
    idle_check("no_flag", 60);

    // Request while busy must not disturb the in-flight frame.
    m = rand_msg(); m.ball = 1; m.miss = 0; m.ng = 0; m.ack = 0;
    m2 = '{ball:0, miss:1, ng:0, ack:0, y:0, vx:0, vy:0, my:5'd3, your:5'd4, serve:0, sf:0};
    model(m); start_req(m);
    fork
      recv_frame(20, w);
      begin repeat (30) @(negedge clock); start_req(m2); end
    join
    idle_check("busy_req", 60);

    // CTS deasserted mid-byte: byte completes, line holds in LOAD, resumes after sync.
    m = rand_msg(); m.ball = 1; m.miss = 0; m.ng = 0; m.ack = 0;
    model(m); start_req(m);
    fork
      recv_frame(200, w);
      begin
        int c, highs;
        repeat (12) @(negedge clock);
        UART_CTS_N = 1'b1;
        repeat (35) @(negedge clock);
        highs = 0;
        repeat (25) begin
          @(negedge clock);
          if (UART_TXD === 1'b1 && busy === 1'b1) highs++;
        end
        chk("cts_hold", highs, 25);
        UART_CTS_N = 1'b0;
        c = 0;
        while (UART_TXD !== 1'b0 && c < 20) begin
          @(negedge clock);
          c++;
        end
        chk("cts_resume_delay", c, 3);
      end
    join
    idle_check("after_cts", 10);

    // Asynchronous reset mid-DATA abandons the frame.
    m = rand_msg(); m.ball = 1; m.miss = 0; m.ng = 0; m.ack = 0;
    start_req(m);
    repeat (12) @(negedge clock);
    #2 reset_L = 1'b0;
    #1;
    chk("async_rst_txd", UART_TXD, 1);
    chk("async_rst_busy", busy, 0);
    repeat (3) @(negedge clock);
    reset_L = 1'b1;
    idle_check("after_reset", 60);
    m = rand_msg(); m.miss = 1; m.ng = 0; m.ack = 0;
    model(m); start_req(m); recv_frame(20, w);
    idle_check("post_reset_frame", 10);

    // Random messages.
    for (int n = 0; n < 10; n++) begin
      m = rand_msg();
      model(m);
      start_req(m);
      if (exp_q.size() > 0) recv_frame(20, w);
      idle_check("rand_idle", 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
